// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter_if
//  Description : Bundle of the requester-side and uart_drive-side handshake
//                signals used by uart_tx_arbiter, plus its status outputs.
//                modport slave  : the arbiter's view of the bundle.
//                modport master : the view of the logic that surrounds it,
//                                 i.e. the requesters plus uart_drive.
//  Signals     : i_req_data   packed requester bytes, req k at [k*W +: W]
//                i_req_valid  per-requester byte valid
//                i_req_last   per-requester last-byte flag, qualified by valid
//                o_req_ready  per-requester ready
//                o_tx_data    byte to uart_drive
//                o_tx_valid   valid to uart_drive
//                i_tx_ready   ready from uart_drive
//                o_grant      one-hot current grant, 0 when idle
//                o_busy       high while a grant is active
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int P_NUM_REQ    = 4,
    parameter int P_DATA_WIDTH = 8
);
    logic [P_NUM_REQ*P_DATA_WIDTH-1:0] i_req_data;
    logic [P_NUM_REQ-1:0]              i_req_valid;
    logic [P_NUM_REQ-1:0]              i_req_last;
    logic [P_NUM_REQ-1:0]              o_req_ready;
    logic [P_DATA_WIDTH-1:0]           o_tx_data;
    logic                              o_tx_valid;
    logic                              i_tx_ready;
    logic [P_NUM_REQ-1:0]              o_grant;
    logic                              o_busy;

    modport slave (
        input  i_req_data,
        input  i_req_valid,
        input  i_req_last,
        input  i_tx_ready,
        output o_req_ready,
        output o_tx_data,
        output o_tx_valid,
        output o_grant,
        output o_busy
    );

    modport master (
        output i_req_data,
        output i_req_valid,
        output i_req_last,
        output i_tx_ready,
        input  o_req_ready,
        input  o_tx_data,
        input  o_tx_valid,
        input  o_grant,
        input  o_busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Shares the single user TX channel of uart_drive among
//                P_NUM_REQ requesters. Round-robin arbitration with packet
//                lock: a grant is held until the requester marks its last
//                byte, its burst limit is reached, or it stalls with valid
//                low for P_STALL_LIMIT cycles. Data path is combinational
//                pass-through from the granted requester to uart_drive.
//  Ports       : i_clk  system clock
//                i_rst  asynchronous active-high reset
//                bus    uart_tx_arbiter_if.slave (requester + TX handshakes,
//                       one-hot grant, busy)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int P_NUM_REQ     = 4,
    parameter int P_DATA_WIDTH  = 8,
    parameter int P_MAX_BURST   = 16,
    parameter int P_STALL_LIMIT = 1024
) (
    input  wire logic           i_clk,
    input  wire logic           i_rst,
    uart_tx_arbiter_if.slave    bus
);

    localparam int c_PTR_W   = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1;
    localparam int c_BURST_W = $clog2(P_MAX_BURST + 1);
    localparam int c_STALL_W = $clog2(P_STALL_LIMIT + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_XFER = 1'b1;

    logic [0:0]           state_q,     state_d;
    logic [P_NUM_REQ-1:0] grant_q,     grant_d;
    logic [c_PTR_W-1:0]   gidx_q,      gidx_d;
    logic [c_PTR_W-1:0]   ptr_q,       ptr_d;
    logic [c_BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [c_STALL_W-1:0] stall_cnt_q, stall_cnt_d;

    logic                 w_any_req;
    logic [c_PTR_W-1:0]   w_winner;
    logic                 w_g_valid;
    logic                 w_g_last;
    logic                 w_hs;
    logic                 w_burst_end;
    logic                 w_stall_end;
    logic                 w_release;
    logic [c_PTR_W-1:0]   w_ptr_next;

    // ------------------------------------------------------------------
    // Round-robin winner: first valid requester at or above the pointer,
    // wrapping modulo P_NUM_REQ (correct for non-power-of-2 counts).
    // ------------------------------------------------------------------
    always_comb begin
        int idx;
        w_any_req = 1'b0;
        w_winner  = '0;
        idx       = 0;
        for (int i = 0; i < P_NUM_REQ; i++) begin
            idx = (int'(ptr_q) + i) % P_NUM_REQ;
            if (!w_any_req && bus.i_req_valid[idx]) begin
                w_any_req = 1'b1;
                w_winner  = c_PTR_W'(idx);
            end
        end
    end

    assign w_g_valid   = bus.i_req_valid[gidx_q];
    assign w_g_last    = bus.i_req_last[gidx_q];
    assign w_hs        = (state_q == S_XFER) && w_g_valid && bus.i_tx_ready;
    assign w_burst_end = (burst_cnt_q == c_BURST_W'(P_MAX_BURST - 1));
    // Backpressure (valid high, ready low) never reaches this term.
    assign w_stall_end = (state_q == S_XFER) && !w_g_valid &&
                         (stall_cnt_q == c_STALL_W'(P_STALL_LIMIT - 1));
    // Last and burst limit on the same handshake collapse into one release.
    assign w_release   = (w_hs && (w_g_last || w_burst_end)) || w_stall_end;
    assign w_ptr_next  = (gidx_q == c_PTR_W'(P_NUM_REQ - 1)) ? '0
                                                             : gidx_q + c_PTR_W'(1);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            ptr_q       <= '0;
            burst_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            ptr_q       <= ptr_d;
            burst_cnt_q <= burst_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        ptr_d       = ptr_q;
        burst_cnt_d = burst_cnt_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_any_req) begin
                    state_d           = S_XFER;
                    grant_d           = '0;
                    grant_d[w_winner] = 1'b1;
                    gidx_d            = w_winner;
                    burst_cnt_d       = '0;
                    stall_cnt_d       = '0;
                end
            end
            S_XFER: begin
                if (w_release) begin
                    // Returning through S_IDLE guarantees an idle cycle
                    // between consecutive grants.
                    state_d     = S_IDLE;
                    grant_d     = '0;
                    ptr_d       = w_ptr_next;
                    burst_cnt_d = '0;
                    stall_cnt_d = '0;
                end else if (w_hs) begin
                    if (burst_cnt_q < c_BURST_W'(P_MAX_BURST))
                        burst_cnt_d = burst_cnt_q + c_BURST_W'(1);
                    stall_cnt_d = '0;
                end else if (!w_g_valid) begin
                    if (stall_cnt_q < c_STALL_W'(P_STALL_LIMIT))
                        stall_cnt_d = stall_cnt_q + c_STALL_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: all gated by the registered state so an asynchronous reset
    // clears them immediately.
    // ------------------------------------------------------------------
    always_comb begin
        bus.o_tx_data   = '0;
        bus.o_tx_valid  = 1'b0;
        bus.o_req_ready = '0;
        bus.o_grant     = grant_q;
        bus.o_busy      = (state_q == S_XFER);
        if (state_q == S_XFER) begin
            bus.o_tx_data           = bus.i_req_data[gidx_q*P_DATA_WIDTH +: P_DATA_WIDTH];
            bus.o_tx_valid          = w_g_valid;
            bus.o_req_ready[gidx_q] = bus.i_tx_ready;
        end
    end

endmodule
`default_nettype wire
